sdram_write_buffer: RTL and testbench



---
 rtl/sdram_pkg.sv | 16 +
 rtl/byte_packer.sv | 30 +++
 rtl/sdram_write_buffer.sv | 164 ++++++++++++++++
 tb/tb_sdram_write_buffer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM write-side feeder: drain FSM encoding and
// burst/frame geometry defaults.
package sdram_pkg;

    localparam int unsigned BURST_LENGTH = 8;
    localparam int unsigned FRAME_WORDS  = 307200;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_WR,
        DATA,
        DONE
    } drain_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs consecutive accepted bytes into little-endian 16-bit words:
// the first byte of a pair becomes the low byte.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data,
    input  logic        accept,
    output logic [15:0] word,
    output logic        word_valid
);

    logic       phase;
    logic [7:0] low;

    assign word       = {data, low};
    assign word_valid = accept && phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 1'b0;
            low   <= '0;
        end else if (accept) begin
            if (!phase) begin
                low <= data;
            end
            phase <= ~phase;
        end
    end

endmodule

// File: rtl/sdram_write_buffer.sv
// Byte-stream to SDRAM burst-write feeder: packs bytes into words, fills a
// two-bank ping-pong buffer and drains each full bank as one burst request.
module sdram_write_buffer
    import sdram_pkg::*;
#(
    parameter int unsigned WordLength   = 16,
    parameter int unsigned AddressWidth = 24,
    parameter int unsigned BurstLength  = BURST_LENGTH,
    parameter int unsigned FrameWords   = FRAME_WORDS
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    i_frame_start,
    input  logic [7:0]              i_byte,
    input  logic                    i_byte_valid,
    output logic                    o_ready,
    output logic                    o_overflow,
    output logic                    ctrl_enable,
    output logic                    ctrl_rw,
    output logic [AddressWidth-1:0] ctrl_addr,
    output logic [WordLength-1:0]   ctrl_data,
    input  logic                    ctrl_valid_wr,
    input  logic                    ctrl_busy
);

    localparam int unsigned IdxWidth = (BurstLength > 1) ? $clog2(BurstLength) : 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(BurstLength - 1);

    drain_state_t state;

    logic [1:0]              full;
    logic [1:0]              full_next;
    logic                    fill_bank;
    logic                    drain_bank;
    logic                    restart_pending;
    logic [IdxWidth-1:0]     fill_idx;
    logic [IdxWidth-1:0]     drain_idx;
    logic [WordLength-1:0]   buffer [2][BurstLength];
    logic [15:0]             packed_word;
    logic                    word_valid;
    logic                    accept;
    logic [AddressWidth-1:0] next_addr;

    // With the invariant that filling always moves on once a bank is full,
    // the fill bank being full means both banks are full.
    assign accept  = i_byte_valid && !full[fill_bank] && !i_frame_start;
    assign o_ready = !(&full);
    assign ctrl_rw = 1'b0;

    assign ctrl_data = buffer[drain_bank][drain_idx];
    assign next_addr = (ctrl_addr == AddressWidth'(FrameWords - BurstLength)) ? '0
                     : ctrl_addr + AddressWidth'(BurstLength);

    byte_packer u_packer (
        .clk        (CLK),
        .rst        (RST || i_frame_start),
        .data       (i_byte),
        .accept     (accept),
        .word       (packed_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge CLK) begin
        if (word_valid) begin
            buffer[fill_bank][fill_idx] <= WordLength'(packed_word);
        end
    end

    // A restart during a burst leaves the draining bank marked full until DONE,
    // so the fill side cannot overwrite words the controller still has to read.
    always_comb begin
        full_next = full;
        if (state == DONE && !ctrl_busy) begin
            full_next[drain_bank] = 1'b0;
        end
        if (i_frame_start) begin
            if (state == IDLE) begin
                full_next = '0;
            end else begin
                full_next[~drain_bank] = 1'b0;
            end
        end else if (word_valid && fill_idx == LastIdx) begin
            full_next[fill_bank] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            full       <= '0;
            fill_bank  <= 1'b0;
            fill_idx   <= '0;
            o_overflow <= 1'b0;
        end else begin
            full <= full_next;
            if (i_frame_start) begin
                fill_idx   <= '0;
                fill_bank  <= (state == IDLE) ? drain_bank : ~drain_bank;
                o_overflow <= 1'b0;
            end else begin
                if (i_byte_valid && full[fill_bank]) begin
                    o_overflow <= 1'b1;
                end
                if (word_valid) begin
                    fill_idx <= fill_idx + IdxWidth'(1);
                    if (fill_idx == LastIdx) begin
                        fill_bank <= ~fill_bank;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= IDLE;
            ctrl_enable     <= 1'b0;
            ctrl_addr       <= '0;
            drain_bank      <= 1'b0;
            drain_idx       <= '0;
            restart_pending <= 1'b0;
        end else begin
            ctrl_enable <= 1'b0;
            if (i_frame_start && state != IDLE) begin
                restart_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (i_frame_start) begin
                        ctrl_addr <= '0;
                    end else if (full[drain_bank] && !ctrl_busy) begin
                        state       <= REQ;
                        ctrl_enable <= 1'b1;
                    end
                end
                REQ: begin
                    state <= WAIT_WR;
                end
                WAIT_WR, DATA: begin
                    if (ctrl_valid_wr) begin
                        if (drain_idx == LastIdx) begin
                            state <= DONE;
                        end else begin
                            drain_idx <= drain_idx + IdxWidth'(1);
                            state     <= DATA;
                        end
                    end
                end
                DONE: begin
                    if (!ctrl_busy) begin
                        drain_idx       <= '0;
                        drain_bank      <= ~drain_bank;
                        ctrl_addr       <= (restart_pending || i_frame_start) ? '0 : next_addr;
                        restart_pending <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_write_buffer.sv
// Directed self-checking bench for sdram_write_buffer with a 16-word frame so
// that address wrap shows up within a few bursts.
module tb_sdram_write_buffer;

    logic        CLK;
    logic        RST;
    logic        i_frame_start;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        o_ready;
    logic        o_overflow;
    logic        ctrl_enable;
    logic        ctrl_rw;
    logic [23:0] ctrl_addr;
    logic [15:0] ctrl_data;
    logic        ctrl_valid_wr;
    logic        ctrl_busy;

    int          tests;
    int          failed;
    int          ready_low;
    logic        force_busy;
    logic        ph;
    logic [7:0]  lo;
    logic [15:0] exp_q[$];
    logic [23:0] addr_q[$];

    sdram_write_buffer #(
        .WordLength   (16),
        .AddressWidth (24),
        .BurstLength  (8),
        .FrameWords   (16)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .i_frame_start (i_frame_start),
        .i_byte        (i_byte),
        .i_byte_valid  (i_byte_valid),
        .o_ready       (o_ready),
        .o_overflow    (o_overflow),
        .ctrl_enable   (ctrl_enable),
        .ctrl_rw       (ctrl_rw),
        .ctrl_addr     (ctrl_addr),
        .ctrl_data     (ctrl_data),
        .ctrl_valid_wr (ctrl_valid_wr),
        .ctrl_busy     (ctrl_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!ph) begin
            lo = b;
            ph = 1'b1;
        end else begin
            exp_q.push_back({b, lo});
            ph = 1'b0;
        end
    endtask

    task automatic send_bytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            i_byte       = base + 8'(i);
            i_byte_valid = 1'b1;
            model_byte(i_byte);
            @(negedge CLK);
        end
        i_byte_valid = 1'b0;
    endtask

    // Streams bytes back-to-back while a small controller model answers each
    // request after `delay` cycles with `nvalid` consume cycles.
    task automatic stream(input int nbytes, input logic [7:0] base, input int delay,
                          input int nvalid, input int max_cycles);
        int          sent = 0;
        int          cd = -1;
        int          vleft = 0;
        int          k = 0;
        logic [15:0] last_w = '0;
        for (int c = 0; c < max_cycles; c++) begin
            if (sent < nbytes) begin
                i_byte       = base + 8'(sent);
                i_byte_valid = 1'b1;
                if (!o_ready) ready_low++;
                model_byte(i_byte);
                sent++;
            end else begin
                i_byte_valid = 1'b0;
            end
            ctrl_valid_wr = 1'b0;
            if (cd == 0) begin
                vleft = nvalid;
                k     = 0;
                cd    = -1;
            end else if (cd > 0) begin
                cd--;
            end
            if (ctrl_enable) begin
                check("req_while_busy", {31'b0, ctrl_busy}, 32'd0);
                addr_q.push_back(ctrl_addr);
                cd = delay;
            end
            if (vleft > 0) begin
                ctrl_valid_wr = 1'b1;
                if (k < 8) last_w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                check("burst_data", {16'b0, ctrl_data}, {16'b0, last_w});
                k++;
                vleft--;
            end
            ctrl_busy = force_busy || cd >= 0 || vleft > 0;
            @(negedge CLK);
            if (sent >= nbytes && cd < 0 && vleft == 0 && exp_q.size() == 0) break;
        end
        i_byte_valid  = 1'b0;
        ctrl_valid_wr = 1'b0;
        ctrl_busy     = force_busy;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        tests = 0; failed = 0; ready_low = 0;
        force_busy = 1'b0; ph = 1'b0; lo = '0;
        RST = 1'b1; i_frame_start = 1'b0; i_byte = '0; i_byte_valid = 1'b0;
        ctrl_valid_wr = 1'b0; ctrl_busy = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        check("rst_ready", {31'b0, o_ready}, 32'd1);
        check("rst_overflow", {31'b0, o_overflow}, 32'd0);
        check("rst_enable", {31'b0, ctrl_enable}, 32'd0);
        check("rst_addr", {8'b0, ctrl_addr}, 32'd0);
        check("rw_write", {31'b0, ctrl_rw}, 32'd0);

        // Pack order and request latency: 0x34,0x12 pairs give 0x1234 words.
        for (int i = 0; i < 16; i++) begin
            i_byte       = (i % 2 == 0) ? 8'h34 : 8'h12;
            i_byte_valid = 1'b1;
            @(negedge CLK);
        end
        i_byte_valid = 1'b0;
        check("lat_idle_cycle", {31'b0, ctrl_enable}, 32'd0);
        @(negedge CLK);
        check("lat_req_cycle", {31'b0, ctrl_enable}, 32'd1);
        check("first_addr", {8'b0, ctrl_addr}, 32'd0);
        @(negedge CLK);
        check("enable_one_cycle", {31'b0, ctrl_enable}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            ctrl_valid_wr = 1'b1;
            check("pack_order", {16'b0, ctrl_data}, 32'h1234);
            @(negedge CLK);
        end
        ctrl_valid_wr = 1'b0;
        repeat (2) @(negedge CLK);
        check("addr_advance", {8'b0, ctrl_addr}, 32'd8);

        // Ping-pong with a slow controller.
        ready_low = 0; addr_q.delete();
        stream(32, 8'h00, 10, 8, 200);
        check("pp_ready_low", ready_low, 0);
        check("pp_overflow", {31'b0, o_overflow}, 32'd0);
        check("pp_nburst", addr_q.size(), 2);
        check("pp_addr0", {8'b0, addr_q[0]}, 32'd8);
        check("pp_addr1_wrap", {8'b0, addr_q[1]}, 32'd0);
        check("pp_drained", exp_q.size(), 0);

        // Extra consume cycle re-presents word 7; next burst starts at word 0.
        addr_q.delete();
        stream(16, 8'h40, 0, 9, 100);
        stream(16, 8'h60, 0, 8, 100);
        check("xv_nburst", addr_q.size(), 2);
        check("xv_addr0", {8'b0, addr_q[0]}, 32'd8);
        check("xv_addr1", {8'b0, addr_q[1]}, 32'd0);
        check("xv_drained", exp_q.size(), 0);

        // Frame start in IDLE zeroes the address, then wrap over 4 bursts.
        i_frame_start = 1'b1;
        @(negedge CLK);
        i_frame_start = 1'b0; ph = 1'b0;
        check("fs_addr_zero", {8'b0, ctrl_addr}, 32'd0);
        ready_low = 0; addr_q.delete();
        stream(64, 8'h80, 0, 8, 300);
        check("wrap_nburst", addr_q.size(), 4);
        check("wrap_a0", {8'b0, addr_q[0]}, 32'd0);
        check("wrap_a1", {8'b0, addr_q[1]}, 32'd8);
        check("wrap_a2", {8'b0, addr_q[2]}, 32'd0);
        check("wrap_a3", {8'b0, addr_q[3]}, 32'd8);
        check("wrap_ready_low", ready_low, 0);
        check("wrap_drained", exp_q.size(), 0);

        // Overflow: controller busy, 32 bytes fill both banks, byte 33 is dropped.
        force_busy = 1'b1; ctrl_busy = 1'b1; ready_low = 0; addr_q.delete();
        stream(32, 8'hA0, 0, 8, 32);
        check("ovf_accept_all", ready_low, 0);
        check("ovf_ready_low", {31'b0, o_ready}, 32'd0);
        check("ovf_not_yet", {31'b0, o_overflow}, 32'd0);
        check("ovf_no_req", addr_q.size(), 0);
        i_byte = 8'hFF; i_byte_valid = 1'b1;
        @(negedge CLK);
        i_byte_valid = 1'b0;
        check("ovf_set", {31'b0, o_overflow}, 32'd1);
        check("ovf_ready_still_low", {31'b0, o_ready}, 32'd0);
        force_busy = 1'b0;
        stream(0, 8'h00, 0, 8, 100);
        check("ovf_nburst", addr_q.size(), 2);
        check("ovf_addr0", {8'b0, addr_q[0]}, 32'd0);
        check("ovf_addr1", {8'b0, addr_q[1]}, 32'd8);
        check("ovf_drained", exp_q.size(), 0);
        check("ovf_ready_back", {31'b0, o_ready}, 32'd1);
        check("ovf_sticky", {31'b0, o_overflow}, 32'd1);

        // Frame restart in the middle of a burst.
        ctrl_busy = 1'b0;
        send_bytes(16, 8'hC0);
        for (int c = 0; c < 20 && !ctrl_enable; c++) @(negedge CLK);
        check("rs_req", {31'b0, ctrl_enable}, 32'd1);
        check("rs_addr", {8'b0, ctrl_addr}, 32'd0);
        ctrl_busy = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            ctrl_valid_wr = 1'b1;
            check("rs_pre_data", {16'b0, ctrl_data}, {16'b0, exp_q.pop_front()});
            @(negedge CLK);
        end
        ctrl_valid_wr = 1'b0;
        send_bytes(3, 8'hD0);
        i_frame_start = 1'b1;
        @(negedge CLK);
        i_frame_start = 1'b0; ph = 1'b0;
        while (exp_q.size() > 5) void'(exp_q.pop_back());
        check("rs_ovf_cleared", {31'b0, o_overflow}, 32'd0);
        check("rs_ready", {31'b0, o_ready}, 32'd1);
        check("rs_addr_held", {8'b0, ctrl_addr}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            ctrl_valid_wr = 1'b1;
            check("rs_post_data", {16'b0, ctrl_data}, {16'b0, exp_q.pop_front()});
            @(negedge CLK);
        end
        ctrl_valid_wr = 1'b0; ctrl_busy = 1'b0;
        repeat (3) @(negedge CLK);
        addr_q.delete();
        stream(16, 8'hE0, 0, 8, 100);
        check("rs_nburst", addr_q.size(), 1);
        check("rs_next_addr", {8'b0, addr_q[0]}, 32'd0);
        check("rs_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
